knn_topk_vote: RTL and testbench
================================

Name: knn_topk_vote

Overview:
- Downstream stage of the KNN distance core. Consumes one (distance, label) pair per cycle for the current test point.
- Keeps the NBR_KNN smallest distances in a sorted register list, updated by insertion.
- After the last data point, runs a sequential majority vote over the kept labels and presents the winning class with a valid/ready handshake.

Parameters:
- DATA_W, 32, distance width (unsigned squared distance from the core)
- LABEL_BITS, 8, label width
- NBR_KNN, 4, list depth K (>=1)
- NBR_LABELS, 4, number of classes; labels >= NBR_LABELS are stored but never voted

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous reset, active-high
- start  input  1  clear the list for a new test point
- dist_valid  input  1  dist_in/label_in valid this cycle
- dist_in  input  DATA_W  candidate distance, unsigned
- label_in  input  LABEL_BITS  candidate label
- last  input  1  qualifies dist_valid: final data point of this test point
- busy  output  1  vote in progress or result pending; inputs ignored
- class_valid  output  1  class_label valid; held until accepted
- class_ready  input  1  consumer accepts result
- class_label  output  LABEL_BITS  winning label
- nn_dist  output  DATA_W  distance of current nearest entry (slot 0)

Behaviour:
- Reset values: every slot dist = all-ones, label = 0, occupied = 0. busy = 0, class_valid = 0, class_label = 0, nn_dist = all-ones. State = IDLE.
- States:
  - IDLE -> COLLECT on start or dist_valid.
  - COLLECT -> VOTE on accepted dist_valid && last.
  - VOTE: NBR_KNN cycles -> DECIDE.
  - DECIDE: NBR_LABELS cycles -> DONE.
  - DONE -> IDLE when class_valid && class_ready.
- Insertion (IDLE/COLLECT only, one per cycle, no stall):
  - Target slot = lowest i where the slot is unoccupied or dist_in < slot_dist[i] (strict).
  - Ties keep the earlier sample ahead of the later one.
  - Slots i..K-2 shift to i+1 and slot K-1 is dropped. If no slot qualifies, the list is unchanged.
  - Takes effect at the clock edge; nn_dist reflects slot 0 the next cycle.
- start (IDLE/COLLECT): clears all slots to reset values.
  - start with dist_valid in the same cycle: clear first, then insert, so the entry lands in slot 0.
  - start with dist_valid && last: the single entry is voted.
- busy = 1 in VOTE, DECIDE and DONE. While busy, dist_valid, last and start are ignored; the list is frozen.
- VOTE: cycle j (0..K-1) reads slot j. If the slot is occupied and its label < NBR_LABELS, that label's counter += 1. Counters are cleared on entry to VOTE. Counter width = clog2(NBR_KNN+1).
- DECIDE: cycle c (0..NBR_LABELS-1) compares count[c] with the running best. Strictly greater replaces it, so on a tie the lowest label index wins. Running best starts at label 0, count 0.
- If no votes were cast, class_label = 0.
- DONE: class_valid = 1 and class_label stable until class_ready is sampled high. class_valid drops the next cycle.
- Latency: last accepted in cycle t -> class_valid first high in cycle t+1+NBR_KNN+NBR_LABELS.
- class_label holds its last value after the handshake until the next DONE.
- Reset asserted mid-operation: immediate return to the reset values above; a pending result is lost.

Optional Feature:
- Macro KNN_WEIGHTED_VOTE_EN.
- Defined: slot j adds weight NBR_KNN-j instead of 1, so slot 0 has the heaviest weight. Counter width = clog2(NBR_KNN*(NBR_KNN+1)/2+1). Tie rule and latency are unchanged.
- Undefined: unit weights as above.

Test Plan:
- Reset, then start, then insert (dist,label) = (50,1),(10,2),(30,3),(20,2),(90,0), with last on (5,1) -> slots (5,1),(10,2),(20,2),(30,3). class_label = 2 at t+9; nn_dist = 5.
- Tie: K=4 with list labels (1),(3),(1),(3) -> class_label = 1 (lowest index). With KNN_WEIGHTED_VOTE_EN the weights are label1 = 4+2 = 6 and label3 = 3+1 = 4, so class_label = 1. Repeat with order 3,1,3,1 -> class_label = 3 weighted, 1 unweighted.
- Short point: start, then a single (7,2) with last -> class_label = 2. Unoccupied slots cast no vote; slots 1..3 stay at all-ones.
- Equal distances: insert (10,1) then (10,3) -> slot0 = (10,1), slot1 = (10,3). Label 9 (>= NBR_LABELS) entries are stored but ignored in the vote.
- Backpressure / busy: hold class_ready = 0 for 5 cycles while driving dist_valid and start -> class_valid and class_label held, list unchanged. Assert class_ready -> class_valid low the next cycle and state IDLE.
- Assert rst during VOTE -> busy = 0, class_valid = 0, nn_dist = all-ones immediately. A following fresh point classifies correctly.

Source files
------------

// File: rtl/knn_topk_vote.sv
// Top-K nearest-neighbour list with sequential majority vote for the KNN distance core.
// Optional macro KNN_WEIGHTED_VOTE_EN: slot j votes with weight NBR_KNN-j instead of 1.
module knn_topk_vote #(
    parameter int DATA_W     = 32,
    parameter int LABEL_BITS = 8,
    parameter int NBR_KNN    = 4,
    parameter int NBR_LABELS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  dist_valid,
    input  logic [DATA_W-1:0]     dist_in,
    input  logic [LABEL_BITS-1:0] label_in,
    input  logic                  last,
    output logic                  busy,
    output logic                  class_valid,
    input  logic                  class_ready,
    output logic [LABEL_BITS-1:0] class_label,
    output logic [DATA_W-1:0]     nn_dist
);

    localparam int IDX_MAX = (NBR_KNN > NBR_LABELS) ? NBR_KNN : NBR_LABELS;
    localparam int IDX_W   = (IDX_MAX > 1) ? $clog2(IDX_MAX) : 1;
`ifdef KNN_WEIGHTED_VOTE_EN
    localparam int CNT_W = $clog2(NBR_KNN * (NBR_KNN + 1) / 2 + 1);
`else
    localparam int CNT_W = $clog2(NBR_KNN + 1);
`endif
    localparam logic [IDX_W-1:0] VOTE_END = IDX_W'(NBR_KNN - 1);
    localparam logic [IDX_W-1:0] DEC_END  = IDX_W'(NBR_LABELS - 1);

    typedef enum logic [2:0] {IDLE, COLLECT, VOTE, DECIDE, DONE} state_t;
    state_t state_reg, state_next;

    logic [DATA_W-1:0]     slot_dist  [NBR_KNN];
    logic [LABEL_BITS-1:0] slot_label [NBR_KNN];
    logic [NBR_KNN-1:0]    slot_occ;
    logic [CNT_W-1:0]      count_reg  [NBR_LABELS];
    logic [IDX_W-1:0]      idx_reg;
    logic [LABEL_BITS-1:0] best_label_reg;
    logic [CNT_W-1:0]      best_count_reg;
    logic [LABEL_BITS-1:0] class_label_reg;

    logic accepting, clear, insert, enter_vote;
    assign accepting  = (state_reg == IDLE) || (state_reg == COLLECT);
    assign clear      = accepting && start;
    assign insert     = accepting && dist_valid;
    assign enter_vote = accepting && (state_next == VOTE);

    // Insertion network: the list is sorted with occupied slots first, so qual is
    // monotonic and the first qualifying slot takes the new entry.
    logic [DATA_W-1:0]     base_dist   [NBR_KNN];
    logic [LABEL_BITS-1:0] base_label  [NBR_KNN];
    logic [NBR_KNN-1:0]    base_occ;
    logic [DATA_W-1:0]     shift_dist  [NBR_KNN];
    logic [LABEL_BITS-1:0] shift_label [NBR_KNN];
    logic [NBR_KNN-1:0]    shift_occ;
    logic [NBR_KNN-1:0]    qual, take_new, take_prev;

    genvar gi;
    generate
        for (gi = 0; gi < NBR_KNN; gi++) begin : g_slot
            assign base_occ[gi]   = clear ? 1'b0 : slot_occ[gi];
            assign base_dist[gi]  = clear ? '1 : slot_dist[gi];
            assign base_label[gi] = clear ? '0 : slot_label[gi];
            assign qual[gi]       = !base_occ[gi] || (dist_in < base_dist[gi]);
            if (gi == 0) begin : g_head
                assign take_new[gi]    = qual[gi];
                assign take_prev[gi]   = 1'b0;
                assign shift_dist[gi]  = base_dist[gi];
                assign shift_label[gi] = base_label[gi];
                assign shift_occ[gi]   = base_occ[gi];
            end else begin : g_tail
                assign take_new[gi]    = qual[gi] && !qual[gi-1];
                assign take_prev[gi]   = qual[gi-1];
                assign shift_dist[gi]  = base_dist[gi-1];
                assign shift_label[gi] = base_label[gi-1];
                assign shift_occ[gi]   = base_occ[gi-1];
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NBR_KNN; i++) begin
                slot_dist[i]  <= '1;
                slot_label[i] <= '0;
                slot_occ[i]   <= 1'b0;
            end
        end else if (accepting) begin
            for (int i = 0; i < NBR_KNN; i++) begin
                if (insert && take_new[i]) begin
                    slot_dist[i]  <= dist_in;
                    slot_label[i] <= label_in;
                    slot_occ[i]   <= 1'b1;
                end else if (insert && take_prev[i]) begin
                    slot_dist[i]  <= shift_dist[i];
                    slot_label[i] <= shift_label[i];
                    slot_occ[i]   <= shift_occ[i];
                end else begin
                    slot_dist[i]  <= base_dist[i];
                    slot_label[i] <= base_label[i];
                    slot_occ[i]   <= base_occ[i];
                end
            end
        end
    end

    // One shared index walks the slots during VOTE and the counters during DECIDE.
    logic                  cur_occ;
    logic [LABEL_BITS-1:0] cur_label;
    logic [CNT_W-1:0]      cur_weight;
    logic [CNT_W-1:0]      cur_count;
    logic                  cur_better;

    always_comb begin
        cur_occ    = 1'b0;
        cur_label  = '0;
        cur_weight = '0;
        cur_count  = '0;
        for (int j = 0; j < NBR_KNN; j++) begin
            if (idx_reg == IDX_W'(j)) begin
                cur_occ   = slot_occ[j];
                cur_label = slot_label[j];
`ifdef KNN_WEIGHTED_VOTE_EN
                cur_weight = CNT_W'(NBR_KNN - j);
`else
                cur_weight = CNT_W'(1);
`endif
            end
        end
        for (int c = 0; c < NBR_LABELS; c++) begin
            if (idx_reg == IDX_W'(c)) begin
                cur_count = count_reg[c];
            end
        end
        cur_better = cur_count > best_count_reg;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < NBR_LABELS; c++) begin
                count_reg[c] <= '0;
            end
        end else if (enter_vote) begin
            for (int c = 0; c < NBR_LABELS; c++) begin
                count_reg[c] <= '0;
            end
        end else if (state_reg == VOTE && cur_occ) begin
            for (int c = 0; c < NBR_LABELS; c++) begin
                if (cur_label == LABEL_BITS'(c)) begin
                    count_reg[c] <= count_reg[c] + cur_weight;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_reg         <= '0;
            best_label_reg  <= '0;
            best_count_reg  <= '0;
            class_label_reg <= '0;
        end else begin
            case (state_reg)
                VOTE: begin
                    if (idx_reg == VOTE_END) begin
                        idx_reg        <= '0;
                        best_label_reg <= '0;
                        best_count_reg <= '0;
                    end else begin
                        idx_reg <= idx_reg + 1'b1;
                    end
                end
                DECIDE: begin
                    if (cur_better) begin
                        best_label_reg <= LABEL_BITS'(idx_reg);
                        best_count_reg <= cur_count;
                    end
                    if (idx_reg == DEC_END) begin
                        idx_reg         <= '0;
                        class_label_reg <= cur_better ? LABEL_BITS'(idx_reg) : best_label_reg;
                    end else begin
                        idx_reg <= idx_reg + 1'b1;
                    end
                end
                default: idx_reg <= '0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (dist_valid && last) begin
                    state_next = VOTE;
                end else if (start || dist_valid) begin
                    state_next = COLLECT;
                end
            end
            COLLECT: if (dist_valid && last) state_next = VOTE;
            VOTE:    if (idx_reg == VOTE_END) state_next = DECIDE;
            DECIDE:  if (idx_reg == DEC_END) state_next = DONE;
            DONE:    if (class_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign busy        = (state_reg == VOTE) || (state_reg == DECIDE) || (state_reg == DONE);
    assign class_valid = (state_reg == DONE);
    assign class_label = class_label_reg;
    assign nn_dist     = slot_dist[0];

endmodule

// File: tb/tb_knn_topk_vote.sv
// Self-checking bench for knn_topk_vote: reference vote model feeding a result scoreboard.
module tb_knn_topk_vote;

    localparam int K   = 4;
    localparam int NL  = 4;
    localparam int DW  = 32;
    localparam int LB  = 8;
    localparam int LAT = 1 + K + NL;
    localparam logic [DW-1:0] ONES = '1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          dist_valid = 1'b0;
    logic [DW-1:0] dist_in = '0;
    logic [LB-1:0] label_in = '0;
    logic          last = 1'b0;
    logic          class_ready = 1'b0;
    logic          busy;
    logic          class_valid;
    logic [LB-1:0] class_label;
    logic [DW-1:0] nn_dist;

    knn_topk_vote #(.DATA_W(DW), .LABEL_BITS(LB), .NBR_KNN(K), .NBR_LABELS(NL)) dut (
        .clk(clk), .rst(rst), .start(start), .dist_valid(dist_valid),
        .dist_in(dist_in), .label_in(label_in), .last(last), .busy(busy),
        .class_valid(class_valid), .class_ready(class_ready),
        .class_label(class_label), .nn_dist(nn_dist)
    );

    always #5 clk = ~clk;

    int tests_run = 0;
    int tests_failed = 0;

    logic [LB-1:0] exp_q[$];
    logic [DW-1:0] exp_nn_q[$];
    logic [DW-1:0] md[$];
    logic [LB-1:0] ml[$];

    // Selection-based reference: repeatedly take the smallest remaining distance,
    // earliest arrival first on equal distances, then vote over the K picks.
    function automatic void model_point(output logic [LB-1:0] lbl, output logic [DW-1:0] nn);
        bit used[64];
        int cnt[NL];
        int best, bc, lab, w;
        for (int i = 0; i < 64; i++) used[i] = 1'b0;
        for (int c = 0; c < NL; c++) cnt[c] = 0;
        nn = ONES;
        for (int r = 0; r < K; r++) begin
            best = -1;
            for (int i = 0; i < md.size(); i++) begin
                if (!used[i] && (best < 0 || md[i] < md[best])) best = i;
            end
            if (best < 0) break;
            used[best] = 1'b1;
            if (r == 0) nn = md[best];
`ifdef KNN_WEIGHTED_VOTE_EN
            w = K - r;
`else
            w = 1;
`endif
            lab = int'(ml[best]);
            if (lab < NL) cnt[lab] += w;
        end
        lbl = '0;
        bc = 0;
        for (int c = 0; c < NL; c++) begin
            if (cnt[c] > bc) begin
                bc = cnt[c];
                lbl = LB'(c);
            end
        end
    endfunction

    task automatic send(input bit st, input bit dv, input logic [DW-1:0] d,
                        input logic [LB-1:0] l, input bit ls);
        logic [LB-1:0] el;
        logic [DW-1:0] en;
        start = st; dist_valid = dv; dist_in = d; label_in = l; last = ls;
        if (st) begin md.delete(); ml.delete(); end
        if (dv) begin md.push_back(d); ml.push_back(l); end
        if (dv && ls) begin
            model_point(el, en);
            exp_q.push_back(el);
            exp_nn_q.push_back(en);
        end
        @(posedge clk); #1;
        start = 1'b0; dist_valid = 1'b0; last = 1'b0;
    endtask

    // Called right after the cycle carrying last; lat counts cycles from that one.
    task automatic get_result(output logic [LB-1:0] lbl, output int lat, output bit timeout,
                              output logic [LB-1:0] e, output logic [DW-1:0] en);
        lat = 1;
        while (!class_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        timeout = !class_valid;
        lbl = class_label;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        en = (exp_nn_q.size() > 0) ? exp_nn_q.pop_front() : ONES;
    endtask

    task automatic accept();
        class_ready = 1'b1;
        @(posedge clk); #1;
        class_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy got %b want 0", busy); end
        tests_run++; if (class_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid got %b want 0", class_valid); end
        tests_run++; if (class_label !== '0) begin tests_failed++; $display("FAIL reset_label got %0d want 0", class_label); end
        tests_run++; if (nn_dist !== ONES) begin tests_failed++; $display("FAIL reset_nn got %h want %h", nn_dist, ONES); end
        $display("[TB] reset checked");
    endtask

    task automatic test_basic();
        logic [LB-1:0] got, e;
        logic [DW-1:0] en;
        int lat; bit to;
        send(1, 0, 0, 0, 0);
        tests_run++; if (nn_dist !== ONES) begin tests_failed++; $display("FAIL basic_start_nn got %h want %h", nn_dist, ONES); end
        send(0, 1, 50, 1, 0);
        tests_run++; if (nn_dist !== 50) begin tests_failed++; $display("FAIL basic_first_nn got %0d want 50", nn_dist); end
        send(0, 1, 10, 2, 0);
        send(0, 1, 30, 3, 0);
        send(0, 1, 20, 2, 0);
        send(0, 1, 90, 0, 0);
        send(0, 1, 5, 1, 1);
        tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("FAIL basic_busy got %b want 1", busy); end
        get_result(got, lat, to, e, en);
        tests_run++;
        if (to) begin tests_failed++; $display("FAIL basic_label got timeout want %0d", e); end
        else if (got !== e) begin tests_failed++; $display("FAIL basic_label got %0d want %0d", got, e); end
        tests_run++; if (lat != LAT) begin tests_failed++; $display("FAIL basic_latency got %0d want %0d", lat, LAT); end
        tests_run++; if (nn_dist !== en) begin tests_failed++; $display("FAIL basic_nn got %0d want %0d", nn_dist, en); end
        accept();
        tests_run++; if (class_valid !== 1'b0) begin tests_failed++; $display("FAIL basic_valid_drop got %b want 0", class_valid); end
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL basic_idle got busy %b want 0", busy); end
        tests_run++; if (class_label !== e) begin tests_failed++; $display("FAIL basic_label_hold got %0d want %0d", class_label, e); end
        $display("[TB] basic point: class %0d latency %0d nn %0d", got, lat, nn_dist);
    endtask

    task automatic test_tie();
        logic [LB-1:0] pat [2][4];
        logic [LB-1:0] got, e;
        logic [DW-1:0] en;
        int lat; bit to;
        pat = '{'{8'd1, 8'd3, 8'd1, 8'd3}, '{8'd3, 8'd1, 8'd3, 8'd1}};
        for (int p = 0; p < 2; p++) begin
            for (int s = 0; s < 4; s++) begin
                send(s == 0, 1, DW'(10 * (s + 1)), pat[p][s], s == 3);
            end
            get_result(got, lat, to, e, en);
            tests_run++;
            if (to) begin tests_failed++; $display("FAIL tie_%0d_label got timeout want %0d", p, e); end
            else if (got !== e) begin tests_failed++; $display("FAIL tie_%0d_label got %0d want %0d", p, got, e); end
            tests_run++; if (lat != LAT) begin tests_failed++; $display("FAIL tie_%0d_latency got %0d want %0d", p, lat, LAT); end
            accept();
            $display("[TB] tie pattern %0d: class %0d", p, got);
        end
    endtask

    task automatic test_short();
        logic [LB-1:0] got, e;
        logic [DW-1:0] en;
        int lat; bit to;
        send(1, 1, 7, 2, 1);
        get_result(got, lat, to, e, en);
        tests_run++;
        if (to) begin tests_failed++; $display("FAIL short_label got timeout want %0d", e); end
        else if (got !== e) begin tests_failed++; $display("FAIL short_label got %0d want %0d", got, e); end
        tests_run++; if (lat != LAT) begin tests_failed++; $display("FAIL short_latency got %0d want %0d", lat, LAT); end
        tests_run++; if (nn_dist !== en) begin tests_failed++; $display("FAIL short_nn got %0d want %0d", nn_dist, en); end
        accept();
        $display("[TB] short point: class %0d nn %0d", got, nn_dist);
    endtask

    task automatic test_equal();
        logic [LB-1:0] labs [3][6];
        int lens [3];
        logic [DW-1:0] dists [3][6];
        logic [LB-1:0] got, e;
        logic [DW-1:0] en;
        int lat; bit to;
        labs  = '{'{8'd1, 8'd1, 8'd3, 8'd3, 8'd3, 8'd3}, '{8'd9, 8'd9, 8'd9, 8'd2, 8'd0, 8'd0}, '{8'd9, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0}};
        dists = '{'{32'd10, 32'd10, 32'd10, 32'd10, 32'd10, 32'd10}, '{32'd1, 32'd2, 32'd3, 32'd8, 32'd0, 32'd0}, '{32'd4, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0}};
        lens  = '{6, 4, 1};
        for (int p = 0; p < 3; p++) begin
            for (int s = 0; s < lens[p]; s++) begin
                send(s == 0, 1, dists[p][s], labs[p][s], s == lens[p] - 1);
            end
            get_result(got, lat, to, e, en);
            tests_run++;
            if (to) begin tests_failed++; $display("FAIL equal_%0d_label got timeout want %0d", p, e); end
            else if (got !== e) begin tests_failed++; $display("FAIL equal_%0d_label got %0d want %0d", p, got, e); end
            tests_run++; if (nn_dist !== en) begin tests_failed++; $display("FAIL equal_%0d_nn got %0d want %0d", p, nn_dist, en); end
            accept();
            $display("[TB] equal/ignored-label point %0d: class %0d nn %0d", p, got, nn_dist);
        end
    endtask

    task automatic test_backpressure();
        logic [LB-1:0] got, e;
        logic [DW-1:0] en;
        int lat; bit to;
        send(1, 1, 5, 2, 0);
        send(0, 1, 8, 3, 0);
        send(0, 1, 6, 2, 1);
        get_result(got, lat, to, e, en);
        tests_run++;
        if (to) begin tests_failed++; $display("FAIL bp_label got timeout want %0d", e); end
        else if (got !== e) begin tests_failed++; $display("FAIL bp_label got %0d want %0d", got, e); end
        for (int c = 0; c < 5; c++) begin
            class_ready = 1'b0; dist_valid = 1'b1; dist_in = 1; label_in = 3;
            last = 1'b1; start = (c % 2 == 0);
            @(posedge clk); #1;
            tests_run++; if (class_valid !== 1'b1) begin tests_failed++; $display("FAIL bp_hold_valid cycle %0d got %b want 1", c, class_valid); end
            tests_run++; if (class_label !== e) begin tests_failed++; $display("FAIL bp_hold_label cycle %0d got %0d want %0d", c, class_label, e); end
            tests_run++; if (nn_dist !== en) begin tests_failed++; $display("FAIL bp_hold_nn cycle %0d got %0d want %0d", c, nn_dist, en); end
            tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("FAIL bp_hold_busy cycle %0d got %b want 1", c, busy); end
        end
        start = 1'b0; dist_valid = 1'b0; last = 1'b0;
        accept();
        tests_run++; if (class_valid !== 1'b0) begin tests_failed++; $display("FAIL bp_release_valid got %b want 0", class_valid); end
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL bp_release_idle got busy %b want 0", busy); end
        $display("[TB] backpressure point: class %0d held 5 cycles", got);
        // Continue the frozen list without start: ignored inputs must not have leaked in.
        send(0, 1, 100, 0, 1);
        get_result(got, lat, to, e, en);
        tests_run++;
        if (to) begin tests_failed++; $display("FAIL bp_frozen_label got timeout want %0d", e); end
        else if (got !== e) begin tests_failed++; $display("FAIL bp_frozen_label got %0d want %0d", got, e); end
        tests_run++; if (nn_dist !== en) begin tests_failed++; $display("FAIL bp_frozen_nn got %0d want %0d", nn_dist, en); end
        accept();
        $display("[TB] frozen-list continuation: class %0d nn %0d", got, nn_dist);
    endtask

    task automatic test_reset_mid();
        logic [LB-1:0] got, e;
        logic [DW-1:0] en;
        int lat; bit to;
        send(1, 1, 3, 1, 0);
        send(0, 1, 4, 1, 1);
        @(posedge clk); #1;
        tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("FAIL rstmid_busy_before got %b want 1", busy); end
        #2 rst = 1'b1;
        #1;
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL rstmid_busy got %b want 0", busy); end
        tests_run++; if (class_valid !== 1'b0) begin tests_failed++; $display("FAIL rstmid_valid got %b want 0", class_valid); end
        tests_run++; if (nn_dist !== ONES) begin tests_failed++; $display("FAIL rstmid_nn got %h want %h", nn_dist, ONES); end
        void'(exp_q.pop_front());
        void'(exp_nn_q.pop_front());
        md.delete(); ml.delete();
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk); #1;
        send(1, 1, 9, 3, 0);
        send(0, 1, 2, 3, 0);
        send(0, 1, 5, 0, 1);
        get_result(got, lat, to, e, en);
        tests_run++;
        if (to) begin tests_failed++; $display("FAIL rstmid_fresh_label got timeout want %0d", e); end
        else if (got !== e) begin tests_failed++; $display("FAIL rstmid_fresh_label got %0d want %0d", got, e); end
        tests_run++; if (lat != LAT) begin tests_failed++; $display("FAIL rstmid_fresh_latency got %0d want %0d", lat, LAT); end
        accept();
        $display("[TB] reset mid-vote then fresh point: class %0d", got);
    endtask

    task automatic test_back_to_back();
        logic [LB-1:0] got, e;
        logic [DW-1:0] en;
        int lat; bit to;
        for (int p = 0; p < 6; p++) begin
            for (int s = 0; s < 6; s++) begin
                send(s == 0, 1, DW'($urandom_range(0, 40)), LB'($urandom_range(0, 5)), s == 5);
            end
            get_result(got, lat, to, e, en);
            tests_run++;
            if (to) begin tests_failed++; $display("FAIL b2b_%0d_label got timeout want %0d", p, e); end
            else if (got !== e) begin tests_failed++; $display("FAIL b2b_%0d_label got %0d want %0d", p, got, e); end
            tests_run++; if (nn_dist !== en) begin tests_failed++; $display("FAIL b2b_%0d_nn got %0d want %0d", p, nn_dist, en); end
            accept();
            $display("[TB] random point %0d: class %0d nn %0d", p, got, nn_dist);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_tie();
        test_short();
        test_equal();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got no completion want summary");
        $fatal(1, "watchdog expired");
    end

endmodule
